i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning clk cycles per BCLK half-period (legal range >=2).
REQ-002 SHALL have parameter DATA_W, default 24, meaning the sample width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: run request.
REQ-006 SHALL have port in_data, input, DATA_W bits: signed filtered sample from the upstream FIR stage.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: holding register is empty.
REQ-009 SHALL have port bclk, output, 1 bit: serial bit clock.
REQ-010 SHALL have port lrclk, output, 1 bit: word select (0 = left, 1 = right).
REQ-011 SHALL have port sdata, output, 1 bit: serial data, MSB first.
REQ-012 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame starts with no sample held.

Function
REQ-013 Clock divider: counter runs 0..CLK_DIV-1; bclk toggles on wrap while RUN.
- Wrap with bclk=1 is the "fall tick".
- All outputs except bclk change only on fall ticks.
REQ-014 Frame: 64 slots k=0..63, one BCLK period each; lrclk = (k>=32); frame rate = clk/(128*CLK_DIV).
REQ-015 Channel slot j = k mod 32:
- j=1..24 carry sample bits 23..0 (I2S one-bit delay).
- j=0 and j=25..31 carry 0.
- The same sample is sent on left and right.
REQ-016 Handshake:
- in_ready = !hold_valid.
- A transfer occurs when in_valid && in_ready on a clk edge; hold <= in_data and hold_valid <= 1.
REQ-017 Consume, at the fall tick entering k=0:
- If hold_valid: frame_reg <= hold and hold_valid <= 0.
- Else: frame_reg <= 0 and underrun pulses for exactly 1 clk.
REQ-018 Simultaneous transfer and k=0 consume with hold empty: the frame underruns (zeros, underrun pulse) and the new sample stays in hold for the next frame.
REQ-019 Latency: a sample held before the k=0 tick has its MSB on sdata starting at the fall tick entering k=1 of that frame.
REQ-020 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN when en=1; divider cleared; first fall tick enters k=0.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1 before the fall tick that ends k=63.
- DRAIN->IDLE at the fall tick ending k=63.
REQ-021 In IDLE: bclk=0, lrclk=1, sdata=0, divider held at 0, hold register retained, handshake still active.
REQ-022 No arithmetic is performed; in_data is serialized verbatim (two's complement).

Reset
REQ-023 On reset=1 at a clk edge, the following SHALL hold from the next edge:
- state=IDLE, bclk=0, lrclk=1, sdata=0, underrun=0.
- hold_valid=0, so in_ready=1.
- Divider, slot counter, hold and frame_reg = 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately and discard any held sample.

Structure
REQ-025 Package i2s_pkg SHALL hold:
- the state enum {IDLE, RUN, DRAIN};
- SLOTS_PER_CH=32, SLOTS_PER_FRAME=64;
- DATA_W default 24.
REQ-026 Sub-module i2s_clk_div SHALL generate bclk and the fall/rise tick strobes from CLK_DIV, with clear and enable inputs.

Verification
REQ-027 Reset with CLK_DIV=2: bclk=0, lrclk=1, sdata=0, in_ready=1, underrun=0; outputs stay static while en=0.
REQ-028 Hold 24'h800001, then set en=1:
- left slots 1 and 24 carry 1, all other left slots 0, and the right channel is identical;
- lrclk is low for 32 BCLKs, then high for 32.
REQ-029 en=1 with in_valid=0:
- sdata is 0 for every slot;
- underrun pulses once per frame, exactly 1 clk wide, at k=0.
REQ-030 Offer 24'h123456 then 24'hABCDEF back-to-back:
- in_ready falls after the first transfer and rises 1 clk after the next k=0 tick;
- frames carry 123456 then ABCDEF, with no underrun.
REQ-031 Drop en at k=40: serialization completes through k=63, then IDLE (bclk=0, lrclk=1); re-asserting en restarts at k=0.
REQ-032 Assert reset at k=10 with a sample held: outputs take reset values on the next clk, in_ready=1, and the held sample is never transmitted.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned SLOTS_PER_CH    = 32;
  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned DEFAULT_DATA_W  = 24;

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK generator: counts CLK_DIV clk cycles per half-period and strobes
// the edge on which bclk falls (fall tick) or rises (rise tick).
module i2s_clk_div #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall_tick,
  output logic o_rise_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_bclk;
  logic          w_wrap;

  assign w_wrap      = i_en && !i_clr && (r_cnt == CW'(CLK_DIV - 1));
  assign o_fall_tick = w_wrap && r_bclk;
  assign o_rise_tick = w_wrap && !r_bclk;
  assign o_bclk      = r_bclk;

  // Divider counter and bclk toggle on wrap; clear parks bclk low.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register fed by a valid/ready
// handshake, 64-slot frame, same sample on left and right channels.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam logic [5:0] LAST_SLOT = 6'(SLOTS_PER_FRAME - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [5:0]        r_slot;
  logic [5:0]        w_slot_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_frame;
  logic              r_hold_valid;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_underrun;
  logic              w_fall;
  logic              w_unused_rise;
  logic              w_div_clr;
  logic              w_div_en;
  logic              w_advance;
  logic              w_enter_k0;
  logic              w_xfer;
  logic              w_bit;

  i2s_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_div_clr),
    .i_en       (w_div_en),
    .o_bclk     (bclk),
    .o_fall_tick(w_fall),
    .o_rise_tick(w_unused_rise)
  );

  assign w_xfer     = in_valid && !r_hold_valid;
  assign in_ready   = !r_hold_valid;
  assign w_slot_nxt = r_slot + 6'd1;
  assign lrclk      = r_lrclk;
  assign sdata      = r_sdata;
  assign underrun   = r_underrun;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; en wins over the frame-end tick while draining.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en)                                w_state_nxt = RUN;
        else if (w_fall && r_slot == LAST_SLOT) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: divider control and slot-advance strobes.
  always_comb begin
    w_div_clr  = (r_state == IDLE);
    w_div_en   = (r_state != IDLE);
    w_advance  = w_fall && (w_state_nxt != IDLE);
    w_enter_k0 = w_advance && (r_slot == LAST_SLOT);
  end

  // Bit for the slot being entered: channel slot j carries bit DATA_W-j.
  always_comb begin
    w_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (w_slot_nxt[4:0] == 5'(DATA_W - i)) w_bit = r_frame[i];
    end
  end

  // Holding register, frame register, slot counter and serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot       <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_frame      <= '0;
      r_lrclk      <= 1'b1;
      r_sdata      <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_xfer) begin
        r_hold       <= in_data;
        r_hold_valid <= 1'b1;
      end
      // Parking the slot at 63 makes the first fall tick wrap into k=0.
      if (r_state == IDLE && en) r_slot <= LAST_SLOT;
      if (w_advance) begin
        r_slot  <= w_slot_nxt;
        r_lrclk <= w_slot_nxt[5];
        r_sdata <= w_bit;
        if (w_enter_k0) begin
          if (r_hold_valid) begin
            r_frame      <= r_hold;
            r_hold_valid <= 1'b0;
          end else begin
            r_frame    <= '0;
            r_underrun <= 1'b1;
          end
        end
      end else if (w_fall) begin
        r_lrclk <= 1'b1;
        r_sdata <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with CLK_DIV=2, DATA_W=24.
module tb_i2s_tx;

  localparam int unsigned CD = 2;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          reset, en, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, bclk, lrclk, sdata, underrun;

  i2s_tx #(.CLK_DIV(CD), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] s;
    bit          present;
    logic [31:0] exp_ch;
  } vec_t;

  vec_t        tbl[6];
  int          total = 0;
  int          bad = 0;
  bit          fell, bprev, ur_prev, ir_prev;
  int          ur_wide = 0;
  logic [63:0] cap_sd, cap_lr;
  logic        k0_ur, k0_ir, k0_irp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    ir_prev = in_ready;
    @(posedge clk);
    #1;
    fell  = bprev && !bclk;
    bprev = bclk;
    if (underrun && ur_prev) ur_wide++;
    ur_prev = underrun;
  endtask

  task automatic next_fall();
    bit got = 1'b0;
    for (int n = 0; n < 4 * CD + 4 && !got; n++) begin
      tick();
      got = fell;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fall_timeout: no bclk fall within %0d clk", 4 * CD + 4);
    end
  endtask

  task automatic frame_k0();
    next_fall();
    cap_sd     = '0;
    cap_lr     = '0;
    cap_sd[63] = sdata;
    cap_lr[63] = lrclk;
    k0_ur      = underrun;
    k0_ir      = in_ready;
    k0_irp     = ir_prev;
  endtask

  task automatic capture_rest(input int drop_at);
    for (int s = 1; s < 64; s++) begin
      next_fall();
      cap_sd[63-s] = sdata;
      cap_lr[63-s] = lrclk;
      if (s == drop_at) en = 1'b0;
    end
  endtask

  task automatic offer(input logic [23:0] s);
    in_data  = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_frame(input string nm, input logic [31:0] exp_ch);
    chk({nm, "_left"}, 64'(cap_sd[63:32]), 64'(exp_ch));
    chk({nm, "_right"}, 64'(cap_sd[31:0]), 64'(exp_ch));
    chk({nm, "_lrclk"}, cap_lr, {32'h0, 32'hFFFF_FFFF});
  endtask

  initial begin
    int chg;
    logic b0, l0, s0;

    tbl[0] = '{24'h800001, 1'b1, 32'h4000_0080};
    tbl[1] = '{24'h123456, 1'b1, 32'h091A_2B00};
    tbl[2] = '{24'hABCDEF, 1'b1, 32'h55E6_F780};
    tbl[3] = '{24'h000000, 1'b0, 32'h0000_0000};
    tbl[4] = '{24'hFFFFFF, 1'b1, 32'h7FFF_FF80};
    tbl[5] = '{24'h000000, 1'b0, 32'h0000_0000};

    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    bprev = 1'b0; ur_prev = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_bclk", 64'(bclk), 0);
    chk("rst_lrclk", 64'(lrclk), 1);
    chk("rst_sdata", 64'(sdata), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_underrun", 64'(underrun), 0);

    chg = 0; b0 = bclk; l0 = lrclk; s0 = sdata;
    repeat (20) begin
      tick();
      if (bclk !== b0 || lrclk !== l0 || sdata !== s0 || underrun !== 1'b0) chg++;
    end
    chk("idle_static", 64'(chg), 0);

    // Table-driven frames: each entry's sample is offered during the previous frame.
    offer(tbl[0].s);
    chk("in_ready_after_xfer", 64'(in_ready), 0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_k0();
      chk($sformatf("v%0d_underrun", i), 64'(k0_ur), 64'(!tbl[i].present));
      chk($sformatf("v%0d_ready_k0", i), 64'(k0_ir), 1);
      chk($sformatf("v%0d_ready_pre_k0", i), 64'(k0_irp), 64'(!tbl[i].present));
      if (i + 1 < 6 && tbl[i+1].present) begin
        offer(tbl[i+1].s);
        chk($sformatf("v%0d_ready_low", i), 64'(in_ready), 0);
      end
      capture_rest(-1);
      chk_frame($sformatf("v%0d", i), tbl[i].exp_ch);
    end

    // Transfer landing on the k=0 tick with hold empty: underrun now, sample next frame.
    repeat (3) tick();
    in_data = 24'h5A5A5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("simul_is_k0", 64'(fell), 1);
    chk("simul_underrun", 64'(underrun), 1);
    chk("simul_ready", 64'(in_ready), 0);
    cap_sd = '0; cap_lr = '0; cap_sd[63] = sdata; cap_lr[63] = lrclk;
    capture_rest(-1);
    chk_frame("simul_zero", 32'h0);
    frame_k0();
    chk("simul_next_underrun", 64'(k0_ur), 0);
    capture_rest(-1);
    chk_frame("simul_next", 32'h2D2D_2D00);

    // Drop en at k=40: frame completes, then idles.
    offer(24'hC3C3C3);
    frame_k0();
    chk("drain_underrun", 64'(k0_ur), 0);
    capture_rest(40);
    chk_frame("drain", 32'h61E1_E180);
    next_fall();
    chk("idle_bclk", 64'(bclk), 0);
    chk("idle_lrclk", 64'(lrclk), 1);
    chk("idle_sdata", 64'(sdata), 0);
    chg = 0;
    repeat (20) begin
      tick();
      if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0) chg++;
    end
    chk("drain_idle_static", 64'(chg), 0);
    offer(24'h800001);
    en = 1'b1;
    frame_k0();
    chk("restart_underrun", 64'(k0_ur), 0);
    chk("restart_lrclk_k0", 64'(cap_lr[63]), 0);
    capture_rest(-1);
    chk_frame("restart", 32'h4000_0080);

    // Reset at k=10 with a sample held: it must never be sent.
    frame_k0();
    chk("pre_rst_underrun", 64'(k0_ur), 1);
    offer(24'h777777);
    chk("pre_rst_ready", 64'(in_ready), 0);
    for (int s = 1; s <= 10; s++) next_fall();
    repeat (2) tick();
    reset = 1'b1; en = 1'b0;
    tick();
    chk("midrst_bclk", 64'(bclk), 0);
    chk("midrst_lrclk", 64'(lrclk), 1);
    chk("midrst_sdata", 64'(sdata), 0);
    chk("midrst_underrun", 64'(underrun), 0);
    chk("midrst_ready", 64'(in_ready), 1);
    reset = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    frame_k0();
    chk("post_rst_underrun", 64'(k0_ur), 1);
    capture_rest(-1);
    chk_frame("post_rst", 32'h0);
    en = 1'b0;

    chk("underrun_width", 64'(ur_wide), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
